// File: rtl/demux_8_stream.sv
// demux_8_stream: 1-to-2 byte-stream demultiplexer with one FIFO per output port.
//
// Each accepted byte is written into the FIFO chosen by sel. Each port drains its
// own FIFO with a valid/ready handshake. The ports are independent, so a stalled
// port never blocks traffic routed to the other one.
//
// Parameters
//   DEPTH       entries per output FIFO (power of two, >= 2)
//
// Ports
//   clk                     single clock, rising edge
//   rst                     synchronous reset, active high
//   sel                     route select for the offered byte (0 -> port 0, 1 -> port 1)
//   in_valid, in_data[7:0]  source offer
//   in_ready                NOT full of the FIFO currently selected by sel (combinational)
//   outN_valid, outN_data   head of FIFO N (data is don't-care while valid is low)
//   outN_ready              sink N takes the head byte
//   cnt0, cnt1 [15:0]       bytes delivered per port, wrapping at 16 bits
//                           (present only when DEMUX_8_STREAM_CNT_EN is defined)
//
// Build option: `define DEMUX_8_STREAM_CNT_EN adds the per-port delivery counters.
module demux_8_stream #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out0_valid,
    output logic [7:0] out0_data,
    input  logic       out0_ready,
    output logic       out1_valid,
    output logic [7:0] out1_data,
    input  logic       out1_ready
`ifdef DEMUX_8_STREAM_CNT_EN
    ,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]         full;
    logic [1:0]         push;
    logic [1:0]         pop;
    logic [1:0]         valid;
    logic [1:0]         out_ready;
    logic [1:0][7:0]    head;
    logic               accept;

    assign out_ready = {out1_ready, out0_ready};

    // Full is judged on registered occupancy only, so a pop in the same cycle
    // never makes room for a push into a full FIFO.
    assign in_ready = ~full[sel];
    assign accept   = in_valid & in_ready;

    for (genvar i = 0; i < 2; i++) begin : g_port
        logic [7:0]    mem [DEPTH];
        logic [AW-1:0] wptr;
        logic [AW-1:0] rptr;
        logic [CW-1:0] occ;

        assign full[i]  = (occ == CW'(DEPTH));
        assign valid[i] = (occ != '0);
        assign push[i]  = accept & (sel == (i != 0));
        assign pop[i]   = valid[i] & out_ready[i];
        assign head[i]  = mem[rptr];

        // Pointers are exactly AW bits wide, so DEPTH being a power of two
        // makes the natural rollover the modulo-DEPTH wrap.
        always_ff @(posedge clk) begin
            if (rst) begin
                wptr <= '0;
                rptr <= '0;
                occ  <= '0;
            end else begin
                if (push[i]) wptr <= wptr + 1'b1;
                if (pop[i])  rptr <= rptr + 1'b1;
                occ <= occ + CW'(push[i]) - CW'(pop[i]);
            end
        end

        // Storage has no reset; a write while rst is high is suppressed so a
        // byte in flight during reset leaves no trace.
        always_ff @(posedge clk) begin
            if (push[i] && !rst) mem[wptr] <= in_data;
        end
    end

    assign out0_valid = valid[0];
    assign out1_valid = valid[1];
    assign out0_data  = head[0];
    assign out1_data  = head[1];

`ifdef DEMUX_8_STREAM_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= cnt0 + 16'(pop[0]);
            cnt1 <= cnt1 + 16'(pop[1]);
        end
    end
`endif

endmodule

// File: doc/demux_8_stream.md
DEMUX_8_STREAM -- requirements
Module: demux_8_stream

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the entries per output queue (power of two, >= 2).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 sel  input  1  SHALL be the route select, sampled with each accepted byte: 0 routes to port 0, 1 routes to port 1.
REQ-005 in_valid  input  1  SHALL mean the source offers in_data.
REQ-006 in_data  input  8  SHALL be the byte offered by the source.
REQ-007 in_ready  output  1  SHALL mean the block accepts this cycle.
REQ-008 out0_valid / out1_valid  output  1  SHALL mean the port's head byte is available.
REQ-009 out0_data / out1_data  output  8  SHALL be the port's head byte.
REQ-010 out0_ready / out1_ready  input  1  SHALL mean the port's sink takes the head byte.
REQ-011 cnt0 / cnt1  output  16  SHALL count bytes delivered per port; present only when DEMUX_8_STREAM_CNT_EN is defined.

Function
REQ-012 Each port SHALL have an independent FIFO of DEPTH bytes, with occupancy tracked 0..DEPTH.
REQ-013 in_ready SHALL be combinational and equal to NOT full of the FIFO selected by the current sel.
REQ-014 Accept SHALL occur when in_valid and in_ready are both high; in_data SHALL then be written to FIFO[sel].
REQ-015 Push on a full FIFO SHALL NOT occur, even if that FIFO pops in the same cycle (no pass-through).
REQ-016 outN_valid SHALL be high exactly when FIFO N occupancy is nonzero; outN_data SHALL equal the FIFO N head entry.
REQ-017 Pop SHALL occur when outN_valid and outN_ready are both high; the head SHALL advance one entry.
REQ-018 Latency from accept to outN_valid SHALL be one cycle; an idle path SHALL add no bubbles.
REQ-019 Per-port byte order SHALL be preserved; no ordering SHALL exist across ports.
REQ-020 Simultaneous push and pop on a non-full FIFO SHALL leave occupancy unchanged and keep both bytes correct.
REQ-021 A full port SHALL NOT block traffic selected to the other port.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 outN_ready while outN_valid is low SHALL have no effect.
REQ-024 sel and in_data changing while in_valid is high and in_ready is low SHALL NOT corrupt state; only the accept cycle matters.

Reset
REQ-025 rst high at a clock edge SHALL clear both occupancies and all pointers, even mid-transfer.
REQ-026 During reset, a byte in flight SHALL be discarded and no accept or pop SHALL be registered.
REQ-027 Reset values SHALL be: out0_valid=0, out1_valid=0, in_ready=1 (both FIFOs empty), cnt0=0, cnt1=0.
REQ-028 outN_data SHALL be don't-care while outN_valid is low; FIFO storage SHALL need no reset.

Configuration
REQ-029 With DEMUX_8_STREAM_CNT_EN defined, cnt0 and cnt1 SHALL increment by 1 on each port-0/port-1 pop and wrap from 16'hFFFF to 0.
REQ-030 With DEMUX_8_STREAM_CNT_EN undefined, the cnt ports and counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then sel=0, in_data=8'hA5, one-cycle valid, out0_ready=1 -> out0_valid high the next cycle with 8'hA5; out1_valid stays 0.
REQ-032 out1_ready=0; push 8'h11, 8'h22 with sel=1 -> in_ready=0 while sel=1; switch to sel=0 and push 8'h33 -> accepted, out0_data=8'h33.
REQ-033 Port 1 full, out1_ready=1 and sel=1 with valid in the same cycle -> no push that cycle; the push completes the following cycle; bytes leave as 8'h11, 8'h22, then new.
REQ-034 Port 0 holds one byte; push and pop in the same cycle for 8 cycles of incrementing data -> occupancy stays 1 and the output sequence is in order.
REQ-035 Two bytes queued on port 0; rst asserted for one cycle -> out0_valid=0 and in_ready=1 next cycle; the queued bytes are never delivered.
REQ-036 With DEMUX_8_STREAM_CNT_EN, deliver 65537 bytes on port 1 -> cnt1=1 and cnt0=0.
